// File: rtl/axi4_master_write_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_master_write_engine_pkg
// Description : Shared AXI constants, FSM state type and a clog2 helper for
//               the AXI4 master write engine.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_master_write_engine_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
  localparam int         AXI_4K_BYTES      = 4096;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAITAW = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_master_write_engine_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               visible on popData whenever empty is low. Depth must be a
//               power of two; callers guarantee no push when full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft
  import axi4_master_write_engine_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             push,
  input  logic [Width-1:0] pushData,
  input  logic             pop,
  output logic [Width-1:0] popData,
  output logic             empty
);

  localparam int PtrWidth = clog2(Depth);

  logic [Width-1:0]  mem [Depth];
  logic [PtrWidth:0] wrPtr;
  logic [PtrWidth:0] rdPtr;

  assign empty   = (wrPtr == rdPtr);
  assign popData = mem[rdPtr[PtrWidth-1:0]];

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push)          wrPtr <= wrPtr + 1'b1;
      if (pop && !empty) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge ACLK) begin
    if (push) mem[wrPtr[PtrWidth-1:0]] <= pushData;
  end

endmodule
`default_nettype wire

// File: rtl/axi4_master_write_engine.sv
`default_nettype none
// ============================================================================
// Module      : axi4_master_write_engine
// Description : Splits inner write commands into 4 KB-safe AXI4 INCR bursts,
//               passes data beats through with locally generated WLAST, and
//               reports per-command completion and error from B responses.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_master_write_engine
  import axi4_master_write_engine_pkg::*;
#(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int InnerIFLengthWidth = 16,
  parameter int MaxBurstLen        = 16,
  parameter int MaxOutstanding     = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  output logic [AddressWidth-1:0]       OUTER_AWADDR,
  output logic [7:0]                    OUTER_AWLEN,
  output logic [2:0]                    OUTER_AWSIZE,
  output logic [1:0]                    OUTER_AWBURST,
  output logic [3:0]                    OUTER_AWCACHE,
  output logic [2:0]                    OUTER_AWPROT,
  output logic                          OUTER_AWVALID,
  input  logic                          OUTER_AWREADY,
  output logic [DataWidth-1:0]          OUTER_WDATA,
  output logic [DataWidth/8-1:0]        OUTER_WSTRB,
  output logic                          OUTER_WLAST,
  output logic                          OUTER_WVALID,
  input  logic                          OUTER_WREADY,
  input  logic [1:0]                    OUTER_BRESP,
  input  logic                          OUTER_BVALID,
  output logic                          OUTER_BREADY,
  input  logic [AddressWidth-1:0]       INNER_AWADDR,
  input  logic [InnerIFLengthWidth-1:0] INNER_AWLEN,
  input  logic                          INNER_AWVALID,
  output logic                          INNER_AWREADY,
  input  logic [DataWidth-1:0]          INNER_WDATA,
  input  logic [DataWidth/8-1:0]        INNER_WSTRB,
  input  logic                          INNER_WVALID,
  output logic                          INNER_WREADY,
  output logic                          CMD_DONE,
  output logic                          CMD_ERROR
);

  localparam int BytesPerBeat = DataWidth / 8;
  localparam int SizeLog      = clog2(BytesPerBeat);
  localparam int OutWidth     = clog2(MaxOutstanding) + 1;
  localparam logic [AddressWidth-1:0] LowMask = AddressWidth'(BytesPerBeat - 1);

  state_t                          state;
  state_t                          stateNext;
  logic [AddressWidth-1:0]         rAddr;
  logic [InnerIFLengthWidth-1:0]   rRemain;
  logic [8:0]                      rBeats;
  logic [OutWidth-1:0]             outstanding;
  logic [7:0]                      beatCnt;
  logic                            errAcc;

  logic                            awHs;
  logic                            wHs;
  logic                            bHs;
  logic                            canIssue;
  logic                            lastBurst;
  logic                            acceptCmd;
  logic [12:0]                     bytesToBoundary;
  logic [31:0]                     beatsToBoundary;
  logic [31:0]                     beatsMin;
  logic [8:0]                      issueBeats;
  logic                            wlenEmpty;
  logic [7:0]                      wlenHead;
  logic                            btagEmpty;
  logic                            btagHead;
  logic                            unusedBits;

  assign OUTER_AWSIZE  = 3'(SizeLog);
  assign OUTER_AWBURST = AXI_BURST_INCR;
  assign OUTER_AWCACHE = AXI_CACHE_DEFAULT;
  assign OUTER_AWPROT  = AXI_PROT_DEFAULT;
  assign unusedBits    = OUTER_BRESP[0];

  assign awHs = OUTER_AWVALID & OUTER_AWREADY;
  assign wHs  = OUTER_WVALID & OUTER_WREADY;
  assign bHs  = OUTER_BVALID & OUTER_BREADY;

  // Burst size: smallest of remaining beats, burst cap and beats to the 4 KB line.
  always_comb begin
    bytesToBoundary = 13'(AXI_4K_BYTES) - {1'b0, rAddr[11:0]};
    beatsToBoundary = 32'(bytesToBoundary >> SizeLog);
    beatsMin        = 32'(rRemain);
    if (32'(MaxBurstLen) < beatsMin) beatsMin = 32'(MaxBurstLen);
    if (beatsToBoundary < beatsMin)  beatsMin = beatsToBoundary;
    issueBeats = 9'(beatsMin);
  end

  // Next-state logic and command-side control strobes.
  always_comb begin
    stateNext     = state;
    INNER_AWREADY = 1'b0;
    acceptCmd     = 1'b0;
    canIssue      = (outstanding < OutWidth'(MaxOutstanding));
    lastBurst     = (32'(rRemain) == 32'(rBeats));
    case (state)
      IDLE: begin
        INNER_AWREADY = 1'b1;
        if (INNER_AWVALID && (INNER_AWLEN != '0)) begin
          acceptCmd = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (canIssue) stateNext = WAITAW;
      end
      WAITAW: begin
        if (awHs) stateNext = lastBurst ? IDLE : ISSUE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= stateNext;
  end

  // Command address/remaining tracking and registered AW channel.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rAddr         <= '0;
      rRemain       <= '0;
      rBeats        <= '0;
      OUTER_AWADDR  <= '0;
      OUTER_AWLEN   <= '0;
      OUTER_AWVALID <= 1'b0;
    end else begin
      if (acceptCmd) begin
        rAddr   <= INNER_AWADDR & ~LowMask;
        rRemain <= INNER_AWLEN;
      end
      if ((state == ISSUE) && canIssue) begin
        OUTER_AWADDR  <= rAddr;
        OUTER_AWLEN   <= 8'(issueBeats - 9'd1);
        rBeats        <= issueBeats;
        OUTER_AWVALID <= 1'b1;
      end
      if ((state == WAITAW) && awHs) begin
        OUTER_AWVALID <= 1'b0;
        rAddr         <= rAddr + (AddressWidth'(rBeats) << SizeLog);
        rRemain       <= rRemain - InnerIFLengthWidth'(rBeats);
      end
    end
  end

  // Bursts issued but not yet answered on B; paces ISSUE.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) outstanding <= '0;
    else begin
      case ({awHs, bHs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  sync_fifo_fwft #(.Width(8), .Depth(MaxOutstanding)) uWlenFifo (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .push     (awHs),
    .pushData (OUTER_AWLEN),
    .pop      (wHs & OUTER_WLAST),
    .popData  (wlenHead),
    .empty    (wlenEmpty)
  );

  sync_fifo_fwft #(.Width(1), .Depth(MaxOutstanding)) uBtagFifo (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .push     (awHs),
    .pushData (lastBurst),
    .pop      (bHs),
    .popData  (btagHead),
    .empty    (btagEmpty)
  );

  // Data only flows once the owning burst's AW has been accepted.
  assign OUTER_WVALID = INNER_WVALID & !wlenEmpty;
  assign INNER_WREADY = OUTER_WREADY & !wlenEmpty;
  assign OUTER_WDATA  = wlenEmpty ? '0 : INNER_WDATA;
  assign OUTER_WSTRB  = wlenEmpty ? '0 : INNER_WSTRB;
  assign OUTER_WLAST  = !wlenEmpty && (beatCnt == wlenHead);
  assign OUTER_BREADY = !btagEmpty;

  // Beat position within the current W burst.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)   beatCnt <= '0;
    else if (wHs) beatCnt <= OUTER_WLAST ? 8'd0 : beatCnt + 8'd1;
  end

  // Error accumulation across a command's bursts and completion pulse.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      errAcc    <= 1'b0;
      CMD_DONE  <= 1'b0;
      CMD_ERROR <= 1'b0;
    end else begin
      CMD_DONE  <= bHs & btagHead;
      CMD_ERROR <= bHs & btagHead & (errAcc | OUTER_BRESP[1]);
      if (bHs) errAcc <= btagHead ? 1'b0 : (errAcc | OUTER_BRESP[1]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_master_write_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_master_write_engine
// Description : Directed self-checking bench for axi4_master_write_engine
//               with a small AXI slave and inner data source.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_master_write_engine;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] OUTER_AWADDR;
  logic [7:0]  OUTER_AWLEN;
  logic [2:0]  OUTER_AWSIZE;
  logic [1:0]  OUTER_AWBURST;
  logic [3:0]  OUTER_AWCACHE;
  logic [2:0]  OUTER_AWPROT;
  logic        OUTER_AWVALID;
  logic        OUTER_AWREADY;
  logic [31:0] OUTER_WDATA;
  logic [3:0]  OUTER_WSTRB;
  logic        OUTER_WLAST;
  logic        OUTER_WVALID;
  logic        OUTER_WREADY;
  logic [1:0]  OUTER_BRESP;
  logic        OUTER_BVALID;
  logic        OUTER_BREADY;
  logic [31:0] INNER_AWADDR;
  logic [15:0] INNER_AWLEN;
  logic        INNER_AWVALID;
  logic        INNER_AWREADY;
  logic [31:0] INNER_WDATA;
  logic [3:0]  INNER_WSTRB;
  logic        INNER_WVALID;
  logic        INNER_WREADY;
  logic        CMD_DONE;
  logic        CMD_ERROR;

  int assertCount = 0;
  int failCount   = 0;

  // Slave / monitor state (written only by the monitor process).
  logic [31:0] awAddrQ[$];
  logic [7:0]  awLenQ[$];
  int          wlastQ[$];
  logic        doneErrQ[$];
  int          wBeats  = 0;
  int          wBursts = 0;
  int          bCount  = 0;

  // Knobs written only by the main process.
  int bAllow = 1 << 30;
  int errIdx = -1;

  axi4_master_write_engine #(
    .AddressWidth(32), .DataWidth(32), .InnerIFLengthWidth(16),
    .MaxBurstLen(16), .MaxOutstanding(8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .OUTER_AWADDR(OUTER_AWADDR), .OUTER_AWLEN(OUTER_AWLEN), .OUTER_AWSIZE(OUTER_AWSIZE),
    .OUTER_AWBURST(OUTER_AWBURST), .OUTER_AWCACHE(OUTER_AWCACHE), .OUTER_AWPROT(OUTER_AWPROT),
    .OUTER_AWVALID(OUTER_AWVALID), .OUTER_AWREADY(OUTER_AWREADY),
    .OUTER_WDATA(OUTER_WDATA), .OUTER_WSTRB(OUTER_WSTRB), .OUTER_WLAST(OUTER_WLAST),
    .OUTER_WVALID(OUTER_WVALID), .OUTER_WREADY(OUTER_WREADY),
    .OUTER_BRESP(OUTER_BRESP), .OUTER_BVALID(OUTER_BVALID), .OUTER_BREADY(OUTER_BREADY),
    .INNER_AWADDR(INNER_AWADDR), .INNER_AWLEN(INNER_AWLEN), .INNER_AWVALID(INNER_AWVALID),
    .INNER_AWREADY(INNER_AWREADY), .INNER_WDATA(INNER_WDATA), .INNER_WSTRB(INNER_WSTRB),
    .INNER_WVALID(INNER_WVALID), .INNER_WREADY(INNER_WREADY),
    .CMD_DONE(CMD_DONE), .CMD_ERROR(CMD_ERROR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkValue(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Monitor: observes handshakes between edges, clears on reset.
  initial forever begin
    @(negedge ACLK);
    if (ARESET) begin
      awAddrQ.delete(); awLenQ.delete(); wlastQ.delete(); doneErrQ.delete();
      wBeats = 0; wBursts = 0; bCount = 0;
    end else begin
      if (OUTER_AWVALID && OUTER_AWREADY) begin
        awAddrQ.push_back(OUTER_AWADDR);
        awLenQ.push_back(OUTER_AWLEN);
      end
      if (OUTER_WVALID && OUTER_WREADY) begin
        checkValue("wbeat", {28'd0, OUTER_WSTRB, OUTER_WDATA},
                   {28'd0, 4'b1011, 32'hC0DE0000 | 32'(wBeats)});
        if (OUTER_WLAST) begin
          wlastQ.push_back(wBeats + 1);
          wBursts++;
        end
        wBeats++;
      end
      if (OUTER_BVALID && OUTER_BREADY) bCount++;
      if (CMD_DONE) doneErrQ.push_back(CMD_ERROR);
    end
  end

  // Slave B driver and inner data source, updated just after each edge.
  initial begin
    OUTER_BVALID = 1'b0;
    OUTER_BRESP  = 2'b00;
    INNER_WDATA  = 32'hC0DE0000;
    forever begin
      @(posedge ACLK); #1;
      INNER_WDATA  = 32'hC0DE0000 | 32'(wBeats);
      OUTER_BVALID = !ARESET && (wBursts > bCount) && (bCount < bAllow);
      OUTER_BRESP  = (bCount == errIdx) ? 2'b10 : 2'b00;
    end
  end

  task automatic sendCmd(input logic [31:0] addr, input logic [15:0] len);
    logic ok;
    @(posedge ACLK); #1;
    INNER_AWADDR = addr; INNER_AWLEN = len; INNER_AWVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge ACLK);
      if (INNER_AWREADY) begin ok = 1'b1; break; end
    end
    @(posedge ACLK); #1;
    INNER_AWVALID = 1'b0;
    checkValue("cmd_accept", 64'(ok), 64'd1);
  endtask

  task automatic waitDone(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      if (doneErrQ.size() >= target) break;
    end
    checkValue("done_count", 64'(doneErrQ.size()), 64'(target));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge ACLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int awBase, doneBase, wlBase, b0;
    logic [31:0] holdAddr;
    logic [7:0]  holdLen;
    logic stableOk, sawAw;

    ARESET = 1'b1;
    OUTER_AWREADY = 1'b1; OUTER_WREADY = 1'b1;
    INNER_AWADDR = '0; INNER_AWLEN = '0; INNER_AWVALID = 1'b0;
    INNER_WSTRB = 4'b1011; INNER_WVALID = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);

    // Reset state
    checkValue("rst_awvalid", 64'(OUTER_AWVALID), 64'd0);
    checkValue("rst_inner_awready", 64'(INNER_AWREADY), 64'd1);
    checkValue("rst_wvalid", 64'(OUTER_WVALID), 64'd0);
    checkValue("rst_bready", 64'(OUTER_BREADY), 64'd0);
    checkValue("rst_done", 64'(CMD_DONE), 64'd0);
    checkValue("const_aw", {47'd0, OUTER_AWSIZE, OUTER_AWBURST, OUTER_AWCACHE, OUTER_AWPROT},
               {47'd0, 3'd2, 2'b01, 4'b0011, 3'b000});

    // 1: 4 KB split, 40 beats from 0xFE0
    awBase = awAddrQ.size(); wlBase = wlastQ.size(); doneBase = doneErrQ.size();
    sendCmd(32'h0000_0FE0, 16'd40);
    waitDone(doneBase + 1, 400);
    checkValue("t1_awcount", 64'(awAddrQ.size() - awBase), 64'd3);
    if (awAddrQ.size() >= awBase + 3) begin
      checkValue("t1_aw0", {24'd0, awLenQ[awBase],   awAddrQ[awBase]},   {24'd0, 8'd7,  32'h0FE0});
      checkValue("t1_aw1", {24'd0, awLenQ[awBase+1], awAddrQ[awBase+1]}, {24'd0, 8'd15, 32'h1000});
      checkValue("t1_aw2", {24'd0, awLenQ[awBase+2], awAddrQ[awBase+2]}, {24'd0, 8'd15, 32'h1040});
    end
    checkValue("t1_wlast_count", 64'(wlastQ.size() - wlBase), 64'd3);
    if (wlastQ.size() >= wlBase + 3) begin
      checkValue("t1_wlast0", 64'(wlastQ[wlBase]),   64'd8);
      checkValue("t1_wlast1", 64'(wlastQ[wlBase+1]), 64'd24);
      checkValue("t1_wlast2", 64'(wlastQ[wlBase+2]), 64'd40);
    end
    if (doneErrQ.size() > doneBase) checkValue("t1_err", 64'(doneErrQ[doneBase]), 64'd0);

    // 2: AWREADY withheld for 10 cycles
    doneBase = doneErrQ.size();
    @(posedge ACLK); #1 OUTER_AWREADY = 1'b0;
    sendCmd(32'h0000_2000, 16'd4);
    for (int i = 0; i < 50; i++) begin
      if (OUTER_AWVALID) break;
      @(negedge ACLK);
    end
    checkValue("t2_awvalid_up", 64'(OUTER_AWVALID), 64'd1);
    holdAddr = OUTER_AWADDR; holdLen = OUTER_AWLEN;
    stableOk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (!OUTER_AWVALID || OUTER_AWADDR !== holdAddr || OUTER_AWLEN !== holdLen || INNER_AWREADY)
        stableOk = 1'b0;
    end
    checkValue("t2_stable", 64'(stableOk), 64'd1);
    checkValue("t2_payload", {24'd0, holdLen, holdAddr}, {24'd0, 8'd3, 32'h2000});
    @(posedge ACLK); #1 OUTER_AWREADY = 1'b1;
    waitDone(doneBase + 1, 100);

    // 3: outstanding limit with B withheld
    awBase = awAddrQ.size(); doneBase = doneErrQ.size();
    b0 = bCount; bAllow = b0;
    sendCmd(32'h0000_0000, 16'd256);
    idleCycles(200);
    checkValue("t3_aw_at_limit", 64'(awAddrQ.size() - awBase), 64'd8);
    checkValue("t3_awvalid_low", 64'(OUTER_AWVALID), 64'd0);
    @(posedge ACLK); #1 bAllow = b0 + 1;
    idleCycles(30);
    checkValue("t3_aw_after_b", 64'(awAddrQ.size() - awBase), 64'd9);
    @(posedge ACLK); #1 bAllow = 1 << 30;
    waitDone(doneBase + 1, 600);
    checkValue("t3_aw_total", 64'(awAddrQ.size() - awBase), 64'd16);

    // 4: two commands, SLVERR on second burst of the second command
    doneBase = doneErrQ.size();
    errIdx = bCount + 2;
    sendCmd(32'h0000_3000, 16'd16);
    sendCmd(32'h0000_4000, 16'd32);
    waitDone(doneBase + 2, 300);
    if (doneErrQ.size() >= doneBase + 2) begin
      checkValue("t4_err_cmd1", 64'(doneErrQ[doneBase]),   64'd0);
      checkValue("t4_err_cmd2", 64'(doneErrQ[doneBase+1]), 64'd1);
    end
    errIdx = -1;

    // 5: zero-length command is swallowed
    awBase = awAddrQ.size(); doneBase = doneErrQ.size();
    sendCmd(32'h0000_5000, 16'd0);
    sawAw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      sawAw = sawAw | OUTER_AWVALID;
    end
    checkValue("t5_no_awvalid", 64'(sawAw), 64'd0);
    checkValue("t5_no_done", 64'(doneErrQ.size() - doneBase), 64'd0);

    // 6: asynchronous reset mid-burst
    wlBase = wBeats;
    sendCmd(32'h0000_6000, 16'd16);
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (wBeats - wlBase >= 3) break;
    end
    @(posedge ACLK); #2 ARESET = 1'b1;
    #1;
    checkValue("t6_async_outs",
               {55'd0, OUTER_AWVALID, OUTER_WVALID, OUTER_WLAST, OUTER_BREADY,
                CMD_DONE, CMD_ERROR, INNER_AWREADY, INNER_WREADY},
               {55'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    checkValue("t6_async_aw", {24'd0, OUTER_AWLEN, OUTER_AWADDR}, 64'd0);
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    sendCmd(32'h0000_7000, 16'd4);
    waitDone(1, 100);
    checkValue("t6_awcount", 64'(awAddrQ.size()), 64'd1);
    if (awAddrQ.size() >= 1)
      checkValue("t6_aw", {24'd0, awLenQ[0], awAddrQ[0]}, {24'd0, 8'd3, 32'h7000});
    checkValue("t6_beats", 64'(wBeats), 64'd4);
    if (doneErrQ.size() >= 1) checkValue("t6_err", 64'(doneErrQ[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
`default_nettype wire
